// File: rtl/ff_serializador_paralelo_pkg.sv
// ff_serializador_paralelo_pkg: shared FSM states and sizing constants for the serializer
package ff_serializador_paralelo_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int WIDTH_DEF  = 8;
    localparam int TX_COUNT_W = 8;
endpackage

// File: rtl/ff_serializador_paralelo_if.sv
// ff_serializador_paralelo_if: parallel load handshake and serial output bundle
interface ff_serializador_paralelo_if
    import ff_serializador_paralelo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0]      D;
    logic                  load;
    logic                  ready;
    logic                  sout;
    logic                  sout_valid;
    logic                  done;
    logic [TX_COUNT_W-1:0] tx_count;
    modport master (output D, load, input ready, sout, sout_valid, done, tx_count);
    modport slave  (input D, load, output ready, sout, sout_valid, done, tx_count);
endinterface

// File: rtl/ff_serializador_paralelo.sv
// ff_serializador_paralelo: parallel-in serial-out shifter with load handshake and frame counter
module ff_serializador_paralelo
    import ff_serializador_paralelo_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst,
    ff_serializador_paralelo_if.slave bus
);
    localparam int CW    = $clog2(WIDTH);
    localparam int FIRST = MSB_FIRST ? WIDTH - 1 : 0;
    state_t                state, state_next;
    logic [WIDTH-1:0]      sr, sr_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [TX_COUNT_W-1:0] tx_count;
    logic                  ready, sout, sout_valid, done;
    always_comb begin
        state_next = IDLE;
        sr_next    = sr;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                state_next = bus.load ? SHIFT : IDLE;
                sr_next    = bus.load ? bus.D : sr;
                cnt_next   = bus.load ? '0 : cnt;
            end
            SHIFT: begin
                state_next = (cnt == CW'(WIDTH - 1)) ? DONE : SHIFT;
                sr_next    = MSB_FIRST ? sr << 1 : sr >> 1;
                cnt_next   = cnt + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end
    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            tx_count   <= '0;
            ready      <= 1'b1;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            sr         <= sr_next;
            cnt        <= cnt_next;
            tx_count   <= (state == DONE) ? tx_count + 1'b1 : tx_count;
            ready      <= state_next == IDLE;
            sout       <= (state_next == SHIFT) && sr_next[FIRST];
            sout_valid <= state_next == SHIFT;
            done       <= state_next == DONE;
        end
    end
    assign bus.ready      = ready;
    assign bus.sout       = sout;
    assign bus.sout_valid = sout_valid;
    assign bus.done       = done;
    assign bus.tx_count   = tx_count;
endmodule

// File: tb/tb_ff_serializador_paralelo.sv
// tb_ff_serializador_paralelo: MSB-first and LSB-first serializers checked against a frame-timing reference model
module tb_ff_serializador_paralelo;
    localparam int WIDTH = 8;
    logic clk, rst, load;
    logic [WIDTH-1:0] d;
    int checks = 0, errors = 0, cyc = 0;
    int since = -1;
    logic [WIDTH-1:0] word = '0;
    logic [7:0] cnt_m = '0;
    int last_rise = -1, dones = 0, guard;
    bit spacing_on = 0, prev_v = 0;

    ff_serializador_paralelo_if #(.WIDTH(WIDTH)) m_if ();
    ff_serializador_paralelo_if #(.WIDTH(WIDTH)) l_if ();
    assign m_if.D = d;
    assign m_if.load = load;
    assign l_if.D = d;
    assign l_if.load = load;

    ff_serializador_paralelo #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(m_if));
    ff_serializador_paralelo #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(l_if));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected outputs follow from the cycle offset since the accepting edge.
    task automatic compare();
        logic ev, ed, er, bm, bl;
        ev = since >= 0 && since < WIDTH;
        ed = since == WIDTH;
        er = since < 0;
        bm = ev ? word[WIDTH-1-since] : 1'b0;
        bl = ev ? word[since] : 1'b0;
        chk("m_ready", m_if.ready, er);
        chk("m_valid", m_if.sout_valid, ev);
        chk("m_done", m_if.done, ed);
        chk("m_sout", m_if.sout, bm);
        chk("m_tx_count", m_if.tx_count, cnt_m);
        chk("l_ready", l_if.ready, er);
        chk("l_valid", l_if.sout_valid, ev);
        chk("l_done", l_if.done, ed);
        chk("l_sout", l_if.sout, bl);
        chk("l_tx_count", l_if.tx_count, cnt_m);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) begin
            since = -1;
            cnt_m = '0;
        end else if (since < 0) begin
            if (load) begin
                since = 0;
                word = d;
            end
        end else if (since == WIDTH) begin
            since = -1;
            cnt_m++;
        end else since++;
        #1;
        compare();
        if (m_if.done) dones++;
        if (m_if.sout_valid && !prev_v) begin
            if (spacing_on && last_rise >= 0) chk("load_spacing", cyc - last_rise, WIDTH + 2);
            last_rise = cyc;
        end
        prev_v = m_if.sout_valid;
        @(negedge clk);
    endtask

    task automatic drain();
        load = 0;
        for (int i = 0; i < 3 * WIDTH && since >= 0; i++) step();
        chk("drain_idle", m_if.ready, 1'b1);
    endtask

    initial begin
        rst = 0;
        load = 0;
        d = '0;
        #1 rst = 1;
        #1;
        compare();
        step();
        step();
        rst = 0;
        // Scenario 1 / 2: fixed words, first load right after reset release.
        load = 1;
        d = 8'h55;
        step();
        load = 0;
        d = 8'hFF;
        drain();
        chk("s1_tx_count", m_if.tx_count, 8'd1);
        load = 1;
        d = 8'h8A;
        step();
        load = 0;
        d = 8'h00;
        drain();
        chk("s2_tx_count", m_if.tx_count, 8'd2);
        // Scenario 3: load held high while D changes every cycle.
        spacing_on = 1;
        last_rise = -1;
        load = 1;
        for (int i = 0; i < 35; i++) begin
            d = 8'($urandom);
            step();
        end
        drain();
        spacing_on = 0;
        // Scenario 4: asynchronous reset after three bits.
        load = 1;
        d = 8'($urandom);
        step();
        load = 0;
        step();
        step();
        rst = 1;
        #1;
        chk("s4_ready", m_if.ready, 1'b1);
        chk("s4_valid", m_if.sout_valid, 1'b0);
        chk("s4_sout", m_if.sout, 1'b0);
        chk("s4_done", m_if.done, 1'b0);
        chk("s4_tx_count", m_if.tx_count, 8'd0);
        chk("s4_l_valid", l_if.sout_valid, 1'b0);
        since = -1;
        cnt_m = '0;
        dones = 0;
        @(negedge clk);
        step();
        step();
        chk("s4_no_done", dones, 0);
        rst = 0;
        // Scenario 5: 256 back-to-back random frames, counter must wrap.
        spacing_on = 1;
        last_rise = -1;
        load = 1;
        guard = 0;
        while (dones < 256 && guard < 3000) begin
            d = 8'($urandom);
            step();
            guard++;
        end
        chk("s5_frames", dones, 256);
        drain();
        chk("s5_tx_wrap", m_if.tx_count, 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
